// File: rtl/user_bus_arbiter_pkg.sv
// Shared types and widths for the user-bus round-robin arbiter.
package user_bus_arbiter_pkg;

    localparam int LEN_W = 8;
    localparam int CNT_W = 9;

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} wr_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;

endpackage

// File: rtl/user_bus_arbiter_rr_arbiter.sv
// Round-robin picker: first requester at or above ptr, wrapping upward.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] j;
    logic          hit;

    always_comb begin
        gnt = '0;
        idx = '0;
        hit = 1'b0;
        j   = '0;
        for (int k = 0; k < N; k++) begin
            j = IW'((int'(ptr) + k) % N);
            if (!hit && req[j]) begin
                hit    = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/user_bus_arbiter.sv
// Shares one downstream user bus among N_PORTS requesters; write and read
// directions are granted independently and held for a whole burst.
module user_bus_arbiter
    import user_bus_arbiter_pkg::*;
#(
    parameter int N_PORTS      = 2,
    parameter int C_ADDR_WIDTH = 32,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                                      ACLK,
    input  logic                                      ARESETN,
    input  logic [N_PORTS-1:0]                        s_awvalid,
    input  logic [N_PORTS-1:0][C_ADDR_WIDTH-1:0]      s_awaddr,
    input  logic [N_PORTS-1:0][LEN_W-1:0]             s_awlen,
    output logic [N_PORTS-1:0]                        s_awready,
    input  logic [N_PORTS-1:0][C_DATA_WIDTH-1:0]      s_wdata,
    input  logic [N_PORTS-1:0]                        s_wvalid,
    output logic [N_PORTS-1:0]                        s_wready,
    input  logic [N_PORTS-1:0]                        s_arvalid,
    input  logic [N_PORTS-1:0][C_ADDR_WIDTH-1:0]      s_araddr,
    input  logic [N_PORTS-1:0][LEN_W-1:0]             s_arlen,
    output logic [N_PORTS-1:0]                        s_arready,
    output logic [C_DATA_WIDTH-1:0]                   s_rdata,
    output logic [N_PORTS-1:0]                        s_rvalid,
    output logic                                      m_awvalid,
    output logic [C_ADDR_WIDTH-1:0]                   m_awaddr,
    output logic [LEN_W-1:0]                          m_awlen,
    input  logic                                      m_awready,
    output logic [C_DATA_WIDTH-1:0]                   m_wdata,
    output logic                                      m_wvalid,
    input  logic                                      m_wready,
    output logic                                      m_arvalid,
    output logic [C_ADDR_WIDTH-1:0]                   m_araddr,
    output logic [LEN_W-1:0]                          m_arlen,
    input  logic                                      m_arready,
    input  logic [C_DATA_WIDTH-1:0]                   m_rdata,
    input  logic                                      m_rvalid,
    output logic                                      m_rready
);

    localparam int IW = $clog2(N_PORTS);

    wr_state_e          wr_st;
    rd_state_e          rd_st;
    logic [IW-1:0]      wgnt, wptr, wsel;
    logic [IW-1:0]      rgnt, rptr, rsel;
    logic [N_PORTS-1:0] wsel_oh, rsel_oh;
    logic [LEN_W-1:0]   wcnt;
    logic [CNT_W-1:0]   rcnt;

    rr_arbiter #(.N(N_PORTS)) u_wr_arb (.req(s_awvalid), .ptr(wptr), .gnt(wsel_oh), .idx(wsel));
    rr_arbiter #(.N(N_PORTS)) u_rd_arb (.req(s_arvalid), .ptr(rptr), .gnt(rsel_oh), .idx(rsel));

    logic w_addr_act, w_data_act, r_addr_act, r_data_act;
    logic w_addr_rdy, w_addr_fire, w_data_fire, r_addr_fire;

    assign w_addr_act  = (wr_st == W_ADDR);
    assign w_data_act  = (wr_st == W_DATA);
    assign r_addr_act  = (rd_st == R_ADDR);
    assign r_data_act  = (rd_st == R_DATA);
    assign w_addr_rdy  = m_awready & m_wready;
    assign w_addr_fire = m_awvalid & w_addr_rdy;
    assign w_data_fire = w_data_act & s_wvalid[wgnt] & m_wready;
    assign r_addr_fire = m_arvalid & m_arready;

    // Downstream side: mux from the registered grant, never from live requests.
    assign m_awvalid = w_addr_act & s_awvalid[wgnt] & s_wvalid[wgnt];
    assign m_wvalid  = m_awvalid | (w_data_act & s_wvalid[wgnt]);
    assign m_awaddr  = s_awaddr[wgnt];
    assign m_awlen   = s_awlen[wgnt];
    assign m_wdata   = s_wdata[wgnt];
    assign m_arvalid = r_addr_act & s_arvalid[rgnt];
    assign m_araddr  = s_araddr[rgnt];
    assign m_arlen   = s_arlen[rgnt];
    assign m_rready  = 1'b1;
    assign s_rdata   = m_rdata;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        logic wsel_i, rsel_i;
        assign wsel_i       = (wgnt == IW'(i));
        assign rsel_i       = (rgnt == IW'(i));
        assign s_awready[i] = wsel_i & w_addr_act & w_addr_rdy;
        assign s_wready[i]  = wsel_i & ((w_addr_act & w_addr_rdy) | (w_data_act & m_wready));
        assign s_arready[i] = rsel_i & r_addr_act & m_arready;
        assign s_rvalid[i]  = rsel_i & r_data_act & m_rvalid;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_st <= W_IDLE;
            wgnt  <= '0;
            wptr  <= '0;
            wcnt  <= '0;
        end else begin
            case (wr_st)
                W_IDLE: if (|wsel_oh) begin
                    wgnt  <= wsel;
                    wptr  <= (wsel == IW'(N_PORTS - 1)) ? '0 : wsel + IW'(1);
                    wr_st <= W_ADDR;
                end
                // First beat rides with the address, so awlen beats remain.
                W_ADDR: if (w_addr_fire) begin
                    wcnt  <= s_awlen[wgnt];
                    wr_st <= (s_awlen[wgnt] == '0) ? W_IDLE : W_DATA;
                end
                W_DATA: if (w_data_fire) begin
                    wcnt <= wcnt - LEN_W'(1);
                    if (wcnt == LEN_W'(1)) wr_st <= W_IDLE;
                end
                default: wr_st <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_st <= R_IDLE;
            rgnt  <= '0;
            rptr  <= '0;
            rcnt  <= '0;
        end else begin
            case (rd_st)
                R_IDLE: if (|rsel_oh) begin
                    rgnt  <= rsel;
                    rptr  <= (rsel == IW'(N_PORTS - 1)) ? '0 : rsel + IW'(1);
                    rd_st <= R_ADDR;
                end
                R_ADDR: if (r_addr_fire) begin
                    rcnt  <= CNT_W'(s_arlen[rgnt]) + CNT_W'(1);
                    rd_st <= R_DATA;
                end
                R_DATA: if (m_rvalid) begin
                    rcnt <= rcnt - CNT_W'(1);
                    if (rcnt == CNT_W'(1)) rd_st <= R_IDLE;
                end
                default: rd_st <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_user_bus_arbiter.sv
// Scoreboard bench: expected bus traffic is queued at stimulus time and
// popped as the downstream / upstream handshakes occur.
module tb_user_bus_arbiter;

    localparam int NP = 2;
    localparam int PW = 1;
    localparam int AW = 32;
    localparam int DW = 32;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    logic [NP-1:0]         s_awvalid, s_awready, s_wvalid, s_wready;
    logic [NP-1:0]         s_arvalid, s_arready, s_rvalid;
    logic [NP-1:0][AW-1:0] s_awaddr, s_araddr;
    logic [NP-1:0][7:0]    s_awlen, s_arlen;
    logic [NP-1:0][DW-1:0] s_wdata;
    logic [DW-1:0]         s_rdata, m_wdata, m_rdata;
    logic [AW-1:0]         m_awaddr, m_araddr;
    logic [7:0]            m_awlen, m_arlen;
    logic m_awvalid, m_awready, m_wvalid, m_wready;
    logic m_arvalid, m_arready, m_rvalid, m_rready;

    user_bus_arbiter #(.N_PORTS(NP), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 ACLK = ~ACLK;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_w_cyc = -10;
    int rb1 = 0;

    logic [39:0]      exp_aw[$];
    logic [39:0]      exp_ar[$];
    logic [DW-1:0]    exp_w[$];
    logic [NP+DW-1:0] exp_r[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_wr(input logic [31:0] addr, input logic [7:0] len, input logic [31:0] d0);
        exp_aw.push_back({len, addr});
        for (int b = 0; b <= int'(len); b++) exp_w.push_back(d0 + 32'(b));
    endtask

    task automatic push_rd(input logic [PW-1:0] p, input logic [31:0] addr, input logic [7:0] len);
        logic [NP-1:0] oh;
        oh    = '0;
        oh[p] = 1'b1;
        exp_ar.push_back({len, addr});
        for (int b = 0; b <= int'(len); b++) exp_r.push_back({oh, addr + 32'(b)});
    endtask

    task automatic wr_burst(input logic [PW-1:0] p, input logic [31:0] addr,
                            input logic [7:0] len, input logic [31:0] d0);
        int t;
        @(posedge ACLK); #1;
        s_awvalid[p] = 1'b1; s_awaddr[p] = addr; s_awlen[p] = len;
        s_wvalid[p]  = 1'b1; s_wdata[p]  = d0;
        t = 0;
        do begin @(negedge ACLK); t++; end while (!s_awready[p] && t < 500);
        chk("aw_accept", 64'(s_awready[p]), 64'(1));
        @(posedge ACLK); #1;
        s_awvalid[p] = 1'b0;
        for (int b = 1; b <= int'(len); b++) begin
            s_wdata[p] = d0 + 32'(b);
            t = 0;
            do begin @(negedge ACLK); t++; end while (!s_wready[p] && t < 500);
            if (t >= 500) chk("w_accept", 64'(s_wready[p]), 64'(1));
            @(posedge ACLK); #1;
        end
        s_wvalid[p] = 1'b0;
    endtask

    task automatic rd_burst(input logic [PW-1:0] p, input logic [31:0] addr, input logic [7:0] len);
        int t;
        @(posedge ACLK); #1;
        s_arvalid[p] = 1'b1; s_araddr[p] = addr; s_arlen[p] = len;
        t = 0;
        do begin @(negedge ACLK); t++; end while (!s_arready[p] && t < 500);
        chk("ar_accept", 64'(s_arready[p]), 64'(1));
        @(posedge ACLK); #1;
        s_arvalid[p] = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((exp_w.size() + exp_r.size()) != 0 && t < 1000) begin @(negedge ACLK); t++; end
        chk(tag, 64'(exp_w.size() + exp_r.size()), 64'(0));
    endtask

    task automatic monitor();
        forever begin
            @(negedge ACLK);
            if (m_awvalid && m_awready) begin
                chk("aw_gap", 64'((cyc - last_w_cyc) >= 2), 64'(1));
                if (exp_aw.size() > 0) chk("aw", 64'({m_awlen, m_awaddr}), 64'(exp_aw.pop_front()));
                else chk("aw_unexp", 64'(exp_aw.size()), 64'(1));
            end
            if (m_wvalid && m_wready) begin
                last_w_cyc = cyc;
                if (exp_w.size() > 0) chk("wdata", 64'(m_wdata), 64'(exp_w.pop_front()));
                else chk("w_unexp", 64'(exp_w.size()), 64'(1));
            end
            if (m_arvalid && m_arready) begin
                if (exp_ar.size() > 0) chk("ar", 64'({m_arlen, m_araddr}), 64'(exp_ar.pop_front()));
                else chk("ar_unexp", 64'(exp_ar.size()), 64'(1));
            end
            if (|s_rvalid) begin
                if (s_rvalid[1]) rb1++;
                if (exp_r.size() > 0) chk("rdata", 64'({s_rvalid, s_rdata}), 64'(exp_r.pop_front()));
                else chk("r_unexp", 64'(exp_r.size()), 64'(1));
            end
        end
    endtask

    // Downstream read slave: returns addr+beat for each requested beat.
    task automatic rd_slave();
        logic [31:0] a;
        logic [7:0]  l;
        forever begin
            @(negedge ACLK);
            if (m_arvalid && m_arready) begin
                a = m_araddr;
                l = m_arlen;
                for (int b = 0; b <= int'(l); b++) begin
                    @(posedge ACLK); #1;
                    m_rvalid = 1'b1;
                    m_rdata  = a + 32'(b);
                end
                @(posedge ACLK); #1;
                m_rvalid = 1'b0;
            end
        end
    endtask

    initial begin
        int t;
        int rb_base;
        s_awvalid = '1; s_wvalid = '1; s_arvalid = '1;
        s_awaddr = '0; s_awlen = '0; s_wdata = '0; s_araddr = '0; s_arlen = '0;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        m_rvalid = 1'b0; m_rdata = '0;

        fork
            forever begin @(posedge ACLK); cyc++; end
            monitor();
            rd_slave();
        join_none

        // Reset state, with every requester asserting.
        repeat (2) @(negedge ACLK);
        chk("rst_m_valid", 64'({m_awvalid, m_wvalid, m_arvalid}), 64'(0));
        chk("rst_s_ready", 64'({s_awready, s_wready, s_arready}), 64'(0));
        chk("rst_s_rvalid", 64'(s_rvalid), 64'(0));
        chk("rst_m_rready", 64'(m_rready), 64'(1));
        s_awvalid = '0; s_wvalid = '0; s_arvalid = '0;
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        repeat (2) @(posedge ACLK);

        // Single write: address at t+1, idle at t+2.
        push_wr(32'h100, 8'd0, 32'hA5);
        @(posedge ACLK); #1;
        s_awvalid[0] = 1'b1; s_awaddr[0] = 32'h100; s_awlen[0] = 8'd0;
        s_wvalid[0] = 1'b1; s_wdata[0] = 32'hA5;
        @(negedge ACLK);
        chk("lat_idle", 64'(m_awvalid), 64'(0));
        @(negedge ACLK);
        chk("lat_awvalid", 64'(m_awvalid), 64'(1));
        chk("lat_awaddr", 64'(m_awaddr), 64'(32'h100));
        chk("lat_wdata", 64'(m_wdata), 64'(32'hA5));
        @(posedge ACLK); #1;
        s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b0;
        @(negedge ACLK);
        chk("wr_idle", 64'({m_awvalid, s_awready, s_wready}), 64'(0));

        // Port1 single write leaves the write pointer back at 0.
        push_wr(32'h200, 8'd0, 32'h5A);
        wr_burst(1'b1, 32'h200, 8'd0, 32'h5A);

        // Simultaneous 4-beat writes: port0 then port1.
        push_wr(32'h10, 8'd3, 32'h1000);
        push_wr(32'h20, 8'd3, 32'h2000);
        fork
            wr_burst(1'b0, 32'h10, 8'd3, 32'h1000);
            wr_burst(1'b1, 32'h20, 8'd3, 32'h2000);
        join
        drain("rr_drain");

        // 256-beat read on port1.
        rb_base = rb1;
        push_rd(1'b1, 32'h1000, 8'd255);
        rd_burst(1'b1, 32'h1000, 8'd255);
        drain("rd_drain");
        chk("rd_beats", 64'(rb1 - rb_base), 64'(256));

        // Stray beat while read side idle is dropped.
        repeat (3) @(posedge ACLK);
        #1;
        m_rvalid = 1'b1; m_rdata = 32'hDEAD;
        @(negedge ACLK);
        chk("stray_rvalid", 64'(s_rvalid), 64'(0));
        @(posedge ACLK); #1;
        m_rvalid = 1'b0;

        // Concurrent write (port0) and read (port1) with m_wready toggling.
        push_wr(32'h300, 8'd7, 32'h3000);
        push_rd(1'b1, 32'h2000, 8'd3);
        fork
            wr_burst(1'b0, 32'h300, 8'd7, 32'h3000);
            rd_burst(1'b1, 32'h2000, 8'd3);
            begin
                for (int i = 0; i < 40; i++) begin
                    @(posedge ACLK); #1;
                    m_wready = ~m_wready;
                end
                m_wready = 1'b1;
            end
        join
        drain("conc_drain");

        // Reset while beat 2 of an 8-beat write is on the bus.
        push_wr(32'h400, 8'd7, 32'h4000);
        @(posedge ACLK); #1;
        s_awvalid[0] = 1'b1; s_awaddr[0] = 32'h400; s_awlen[0] = 8'd7;
        s_wvalid[0] = 1'b1; s_wdata[0] = 32'h4000;
        t = 0;
        do begin @(negedge ACLK); t++; end while (!s_awready[0] && t < 500);
        @(posedge ACLK); #1;
        s_awvalid[0] = 1'b0; s_wdata[0] = 32'h4001;
        t = 0;
        do begin @(negedge ACLK); t++; end while (!s_wready[0] && t < 500);
        chk("beat2_ready", 64'(s_wready[0]), 64'(1));
        #1;
        ARESETN = 1'b0;
        #1;
        chk("mid_rst_valid", 64'({m_awvalid, m_wvalid, m_arvalid, s_rvalid}), 64'(0));
        chk("mid_rst_ready", 64'({s_awready, s_wready, s_arready}), 64'(0));
        s_wvalid[0] = 1'b0;
        exp_w.delete();
        repeat (2) @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        repeat (2) @(posedge ACLK);

        // Pointer restarted at 0: port0 wins over port1.
        push_wr(32'h500, 8'd0, 32'h50);
        push_wr(32'h600, 8'd0, 32'h60);
        fork
            wr_burst(1'b0, 32'h500, 8'd0, 32'h50);
            wr_burst(1'b1, 32'h600, 8'd0, 32'h60);
        join
        drain("post_rst_drain");

        repeat (5) @(posedge ACLK);
        chk("left_aw", 64'(exp_aw.size()), 64'(0));
        chk("left_ar", 64'(exp_ar.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/user_bus_arbiter.md
# user_bus_arbiter

Round-robin arbiter that shares one downstream user bus (write address/data, read address/data) among `N_PORTS` upstream requesters, typically several Avalon-slave bridges. Write and read directions are arbitrated independently. A grant is held for a whole burst: one address handshake plus `len+1` data beats. The block sits between the bridges and the single DMA/IO channel that consumes the user bus.

## Interface
- `N_PORTS`, default 2: number of requesters, range 2..8.
- `C_ADDR_WIDTH`, default 32: address width.
- `C_DATA_WIDTH`, default 32: data width.
- Per-port signals are packed vectors; port `i` occupies slice `i`.
- `ACLK` in 1: the only clock.
- `ARESETN` in 1: asynchronous, active-low reset.
- `s_awvalid` in N: write-address request per port.
- `s_awaddr` in N*A: write address per port.
- `s_awlen` in N*8: write burst length minus 1, per port.
- `s_awready` out N: write-address accept.
- `s_wdata` in N*D: write data per port.
- `s_wvalid` in N: write data valid.
- `s_wready` out N: write data accept.
- `s_arvalid` in N: read-address request.
- `s_araddr` in N*A: read address.
- `s_arlen` in N*8: read burst length minus 1.
- `s_arready` out N: read-address accept.
- `s_rdata` out D: read data, broadcast to all ports.
- `s_rvalid` out N: read data valid, granted port only.
- `m_awvalid`, `m_awaddr` [A], `m_awlen` [8]: out, downstream write address.
- `m_awready` in 1: downstream write-address ready.
- `m_wdata` [D], `m_wvalid`: out, downstream write data.
- `m_wready` in 1: downstream write-data ready.
- `m_arvalid`, `m_araddr` [A], `m_arlen` [8]: out, downstream read address.
- `m_arready` in 1: downstream read-address ready.
- `m_rdata` in D: downstream read data.
- `m_rvalid` in 1: downstream read data valid.
- `m_rready` out 1: constant 1; requesters always accept read data.

## Operation
- **Write FSM: W_IDLE → W_ADDR → W_DATA → W_IDLE.**
  - W_IDLE: if any `s_awvalid`, round-robin pick winner `g`, register `wgnt=g`, go to W_ADDR. Otherwise stay.
  - W_ADDR: first beat travels with the address. `m_awvalid = m_wvalid = s_awvalid[g] & s_wvalid[g]`. Address, len and data are muxed from `g`.
  - W_ADDR: `s_awready[g] = s_wready[g] = m_awready & m_wready`.
  - W_ADDR fire (both ready): load `wcnt = awlen`. If `awlen==0` go to W_IDLE, else go to W_DATA.
  - W_DATA: forward `s_wvalid[g]` and `s_wdata[g]`; `s_wready[g] = m_wready`. Each handshake decrements `wcnt`. The handshake at `wcnt==1` goes to W_IDLE.
- **Read FSM: R_IDLE → R_ADDR → R_DATA → R_IDLE.**
  - R_ADDR: forward `g`'s ar signals. On handshake, load `rcnt = arlen+1` (9 bits, max 256) and go to R_DATA.
  - R_DATA: `s_rvalid[g] = m_rvalid`. Each beat decrements `rcnt`. The beat at `rcnt==1` goes to R_IDLE.
- **Non-granted ports:** all ready and valid outputs are 0.
- **Round robin:** separate pointer per direction, 0 after reset. After granting `i`, port `i+1 mod N` gets highest priority; search wraps upward from the pointer.
- **Read/write independence:** a read and a write may be in flight simultaneously, to the same or different ports.
- **Beats outside R_DATA:** `m_rvalid` in R_IDLE or R_ADDR is dropped. A bench assertion flags it.

## Timing
- **Reset values** (asynchronous, immediate, including mid-burst): FSMs idle, pointers 0, counters 0, every valid/ready output 0 except `m_rready=1`. No burst resumes after reset.
- **Arbitration latency:** request seen in IDLE at cycle t; address presented downstream at t+1.
- **Burst gap:** last beat at t, IDLE at t+1, next address at t+2 at the earliest. At least 1 idle cycle per direction.
- **Stability:** grant and mux select are stable for the whole burst. Requests from other ports are ignored until IDLE.
- **Combinational paths:** all outputs are combinational from registered state plus inputs. No ready→valid path through the arbiter.

## Structure
- **Package `user_bus_arbiter_pkg`:** write and read state enums, `LEN_W=8`, `CNT_W=9`.
- **Sub-module `rr_arbiter`:** parameterised `N`. Inputs: request vector and priority pointer. Outputs: one-hot grant and index. Instantiated once per direction.

## Test plan
- **Single write:** port0 single write (`awlen=0`, addr `0x100`, data `0xA5`), ready tied 1 → `m_awaddr=0x100`, `m_wdata=0xA5` at t+1; W_IDLE at t+2.
- **Write round robin:** port0 and port1 request 4-beat writes simultaneously → port0 served, all 4 beats contiguous, then port1. The port1 address must not appear until 1 cycle after port0's last beat.
- **Read burst:** port1 reads `arlen=255` → exactly 256 `s_rvalid[1]` pulses, `s_rvalid[0]` stays 0, R_IDLE after beat 256.
- **Concurrent read/write:** port0 write burst overlapping port1 read burst → both complete with no interleaving errors. `m_wready` toggling 1/0 preserves data order.
- **Reset mid-burst:** `ARESETN` low during beat 2 of 8 → all valids 0 in the same cycle. After release, a new request is granted from pointer 0.
